// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide issue controller:
// instruction class codes, unit op codes and default unit latencies.
package md_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULTU = 4'd1,
    MD_MULT  = 4'd2,
    MD_DIVU  = 4'd3,
    MD_DIV   = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_class_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MULT  = 3'd2,
    OP_DIVU  = 3'd3,
    OP_DIV   = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

endpackage

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the HI/LO multiply/divide unit: decodes the
// md class into op/start, mirrors unit latency for stalls, muxes MFHI/MFLO.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_class,
  input  logic [31:0] e_rs_val,
  input  logic [31:0] e_rt_val,
  input  logic        e_stall_other,
  input  logic        flush,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic [2:0]  md_op,
  output logic        md_start,
  output logic [31:0] md_d1,
  output logic [31:0] md_d2,
  output logic        md_stall,
  output logic [31:0] mf_data,
  output logic        md_err
);

  localparam int unsigned CW = $clog2(DIV_LAT + 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            flush_q;

  logic is_md, is_muldiv, is_mul, is_mt, issue, mbusy;

  always_comb begin
    is_md     = (e_md_class >= MD_MULTU) && (e_md_class <= MD_MFLO);
    is_muldiv = (e_md_class >= MD_MULTU) && (e_md_class <= MD_DIV);
    is_mul    = (e_md_class == MD_MULTU) || (e_md_class == MD_MULT);
    is_mt     = (e_md_class == MD_MTHI) || (e_md_class == MD_MTLO);
    mbusy     = (state_q == ST_RUN);
    issue     = (is_muldiv || is_mt) && !mbusy && !flush && !e_stall_other;
    md_op     = issue ? e_md_class[2:0] : OP_NONE;
    md_start  = issue && is_muldiv;
    md_stall  = is_md && mbusy;
    md_d1     = e_rs_val;
    md_d2     = e_rt_val;
    md_err    = err_q;
    case (e_md_class)
      MD_MFHI: mf_data = md_hi;
      MD_MFLO: mf_data = md_lo;
      default: mf_data = '0;
    endcase
  end

  // Flush this cycle or last cycle masks the check: the unit drops Busy on
  // its own schedule when it commits the in-flight result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | ((mbusy != md_busy) && !flush && !flush_q);
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          state_d = ST_RUN;
          cnt_d   = is_mul ? CW'(MUL_LAT) : CW'(DIV_LAT);
        end
      end
      ST_RUN: begin
        if (flush || (cnt_q == CW'(1))) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      flush_q <= flush;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: a behavioural multiply/divide unit drives Busy and
// HI/LO, and a cycle-indexed busy-window model checks every output each cycle.
module tb_md_issue_ctrl;

  logic        clk, reset;
  logic [3:0]  e_md_class;
  logic [31:0] e_rs_val, e_rt_val;
  logic        e_stall_other, flush;
  logic        md_busy;
  logic [31:0] md_hi, md_lo;
  logic [2:0]  md_op;
  logic        md_start;
  logic [31:0] md_d1, md_d2;
  logic        md_stall;
  logic [31:0] mf_data;
  logic        md_err;

  md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .e_md_class(e_md_class),
    .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
    .e_stall_other(e_stall_other), .flush(flush),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
    .md_op(md_op), .md_start(md_start), .md_d1(md_d1), .md_d2(md_d2),
    .md_stall(md_stall), .mf_data(mf_data), .md_err(md_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural multiply/divide unit ----------------
  int          ucnt;
  logic        force_low;
  logic [63:0] pu;
  logic signed [63:0] ps;
  logic signed [31:0] qs, rsg;
  logic [31:0] qu, ru;

  assign pu  = {32'h0, md_d1} * {32'h0, md_d2};
  assign ps  = $signed({{32{md_d1[31]}}, md_d1}) * $signed({{32{md_d2[31]}}, md_d2});
  assign qs  = (md_d2 == 0) ? 32'sd0 : $signed(md_d1) / $signed(md_d2);
  assign rsg = (md_d2 == 0) ? 32'sd0 : $signed(md_d1) % $signed(md_d2);
  assign qu  = (md_d2 == 0) ? 32'd0 : md_d1 / md_d2;
  assign ru  = (md_d2 == 0) ? 32'd0 : md_d1 % md_d2;
  assign md_busy = (ucnt != 0) && !force_low;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ucnt  <= 0;
      md_hi <= '0;
      md_lo <= '0;
    end else begin
      if (flush && ucnt != 0) ucnt <= 0;
      else if (md_start) ucnt <= (md_op <= 3'd2) ? 5 : 10;
      else if (ucnt != 0) ucnt <= ucnt - 1;
      case (md_op)
        3'd1: begin md_hi <= pu[63:32]; md_lo <= pu[31:0]; end
        3'd2: begin md_hi <= ps[63:32]; md_lo <= ps[31:0]; end
        3'd3: begin md_hi <= ru; md_lo <= qu; end
        3'd4: begin md_hi <= rsg; md_lo <= qs; end
        3'd5: md_hi <= md_d1;
        3'd6: md_lo <= md_d1;
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  int passed = 0;
  int total  = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, got, exp, $time);
  endtask

  // Model: the unit is busy on cycles cyc <= busy_end.
  int cyc = 0;
  int busy_end = -1;
  bit err_m = 0;
  bit pflush = 0;

  task automatic model_step();
    int c;
    bit busy, is_md, is_muldiv, is_mt, iss, st;
    logic [31:0] exp_mf;
    if (reset) begin
      busy_end = -1;
      err_m = 0;
      pflush = 0;
    end
    c = int'(e_md_class);
    busy = (cyc <= busy_end);
    is_md = (c >= 1 && c <= 8);
    is_muldiv = (c >= 1 && c <= 4);
    is_mt = (c == 5 || c == 6);
    iss = (is_muldiv || is_mt) && !busy && !flush && !e_stall_other;
    st = iss && is_muldiv;
    exp_mf = (c == 7) ? md_hi : (c == 8) ? md_lo : 32'h0;
    check("m_op", {29'h0, md_op}, iss ? 32'(c) : 32'h0);
    check("m_start", {31'h0, md_start}, {31'h0, st});
    check("m_stall", {31'h0, md_stall}, {31'h0, is_md && busy});
    check("m_d1", md_d1, e_rs_val);
    check("m_d2", md_d2, e_rt_val);
    check("m_err", {31'h0, md_err}, {31'h0, err_m});
    if (!(is_md && busy)) check("m_mf", mf_data, exp_mf);
    if (!reset) begin
      if ((busy != md_busy) && !flush && !pflush) err_m = 1;
      if (flush && busy) busy_end = cyc;
      if (st) busy_end = cyc + ((c <= 2) ? 5 : 10);
      pflush = flush;
    end
    cyc++;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] rs, input logic [31:0] rt,
                       input logic so, input logic fl);
    e_md_class = c;
    e_rs_val = rs;
    e_rt_val = rt;
    e_stall_other = so;
    flush = fl;
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] c);
    drive(c, 32'h0, 32'h0, 1'b0, 1'b0);
    adv();
  endtask

  // Hold class c in E until it is no longer stalled; n = stalled cycles.
  task automatic hold(input logic [3:0] c, input logic [31:0] rs, input logic [31:0] rt,
                      output int n);
    n = 999;
    for (int i = 0; i < 30; i++) begin
      drive(c, rs, rt, 1'b0, 1'b0);
      if (!md_stall) begin
        n = i;
        return;
      end
      adv();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    force_low = 1'b0;
    e_md_class = '0; e_rs_val = '0; e_rt_val = '0;
    e_stall_other = 1'b0; flush = 1'b0;

    drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("rst_start", {31'h0, md_start}, 32'h0);
    check("rst_op", {29'h0, md_op}, 32'h0);
    check("rst_stall", {31'h0, md_stall}, 32'h0);
    check("rst_err", {31'h0, md_err}, 32'h0);
    adv();
    run(4'd0);
    reset = 1'b0;

    // MULT 3 * -2
    drive(4'd2, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0);
    check("mult_start", {31'h0, md_start}, 32'h1);
    check("mult_op", {29'h0, md_op}, 32'h2);
    adv();
    for (int i = 0; i < 5; i++) begin
      drive(4'd8, 32'h0, 32'h0, 1'b0, 1'b0);
      check("mult_mflo_stall", {31'h0, md_stall}, 32'h1);
      adv();
    end
    drive(4'd8, 32'h0, 32'h0, 1'b0, 1'b0);
    check("mult_mflo_free", {31'h0, md_stall}, 32'h0);
    check("mult_lo", mf_data, 32'hFFFF_FFFA);
    check("mult_err", {31'h0, md_err}, 32'h0);
    adv();

    // DIVU 7/2 then DIV back-to-back
    drive(4'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu_start", {31'h0, md_start}, 32'h1);
    adv();
    hold(4'd4, 32'd7, 32'd2, n);
    check("div_stall_cycles", 32'(n), 32'd10);
    check("div_start", {31'h0, md_start}, 32'h1);
    adv();
    hold(4'd7, 32'h0, 32'h0, n);
    check("div_mfhi", mf_data, 32'd1);
    adv();
    drive(4'd8, 32'h0, 32'h0, 1'b0, 1'b0);
    check("div_mflo", mf_data, 32'd3);
    adv();

    // MTHI in IDLE
    drive(4'd5, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    check("mthi_op", {29'h0, md_op}, 32'h5);
    check("mthi_start", {31'h0, md_start}, 32'h0);
    adv();
    drive(4'd7, 32'h0, 32'h0, 1'b0, 1'b0);
    check("mthi_nostall", {31'h0, md_stall}, 32'h0);
    check("mthi_mfhi", mf_data, 32'h1234_5678);
    adv();

    // DIV flushed in RUN cycle 4, MULT issues immediately after
    drive(4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    adv();
    run(4'd0); run(4'd0); run(4'd0);
    drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    adv();
    drive(4'd2, 32'd4, 32'd5, 1'b0, 1'b0);
    check("flush_mult_stall", {31'h0, md_stall}, 32'h0);
    check("flush_mult_start", {31'h0, md_start}, 32'h1);
    adv();
    hold(4'd8, 32'h0, 32'h0, n);
    check("flush_mult_lat", 32'(n), 32'd5);
    check("flush_mult_lo", mf_data, 32'd20);
    check("flush_err", {31'h0, md_err}, 32'h0);
    adv();

    // MULT with flush in the same cycle
    drive(4'd2, 32'd9, 32'd9, 1'b0, 1'b1);
    check("fl_start", {31'h0, md_start}, 32'h0);
    check("fl_op", {29'h0, md_op}, 32'h0);
    adv();
    drive(4'd8, 32'h0, 32'h0, 1'b0, 1'b0);
    check("fl_idle", {31'h0, md_stall}, 32'h0);
    check("fl_lo_kept", mf_data, 32'd20);
    adv();

    // e_stall_other holds MULTU for one cycle
    drive(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    check("so_start", {31'h0, md_start}, 32'h0);
    adv();
    drive(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    check("so_retry_start", {31'h0, md_start}, 32'h1);
    check("so_retry_op", {29'h0, md_op}, 32'h1);
    adv();
    hold(4'd7, 32'h0, 32'h0, n);
    check("multu_lat", 32'(n), 32'd5);
    check("multu_hi", mf_data, 32'd1);
    adv();

    // Reset in the middle of RUN drops the stall asynchronously
    drive(4'd4, 32'd1, 32'd1, 1'b0, 1'b0);
    adv();
    drive(4'd8, 32'h0, 32'h0, 1'b0, 1'b0);
    check("pre_rst_stall", {31'h0, md_stall}, 32'h1);
    #2 reset = 1'b1;
    #1 check("async_rst_stall", {31'h0, md_stall}, 32'h0);
    adv();
    run(4'd0);
    reset = 1'b0;
    drive(4'd8, 32'h0, 32'h0, 1'b0, 1'b0);
    check("post_rst_stall", {31'h0, md_stall}, 32'h0);
    adv();

    // Unit Busy forced low during RUN cycle 2
    drive(4'd2, 32'd1, 32'd1, 1'b0, 1'b0);
    adv();
    run(4'd0);
    force_low = 1'b1;
    drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    adv();
    force_low = 1'b0;
    drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("err_set", {31'h0, md_err}, 32'h1);
    adv();
    repeat (8) run(4'd0);
    drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("err_sticky", {31'h0, md_err}, 32'h1);
    adv();
    reset = 1'b1;
    drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("err_cleared", {31'h0, md_err}, 32'h0);
    adv();
    reset = 1'b0;
    run(4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
